// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, registered-read memory between the
// instruction-fetch port and the load/store data port. The data port normally
// wins; a saturating starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants made while a fetch was waiting.
//
// Handshake: a requester raises *_req with its address/data stable and keeps
// it that way until it sees *_gnt high in the same cycle; the access is
// accepted on that clock edge. A read returns *_rvalid for exactly one cycle,
// the cycle after its grant, with *_rdata valid only in that cycle (0
// otherwise). There is no back-pressure on the read return.
module mem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,       // asynchronous, active-low
  // instruction-fetch port (read only)
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  // load/store data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          mem_ce,
  output logic          mem_wre,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  // debug: 1 while the FSM is in RDATA
  output logic          dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic       owner;        // 0 = fetch, 1 = data; meaningful in RDATA only
  logic [3:0] starve_cnt;
  logic       fetch_win;
  logic       data_win;

  // Arbitration: only in IDLE and out of reset; fetch wins when data is idle
  // or when the starvation counter has saturated.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (rst && (state == IDLE)) begin
      fetch_win = if_req && (!d_req || (starve_cnt == LIMIT));
      data_win  = d_req && !fetch_win;
    end
  end

  // State register, read owner and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (fetch_win) begin
        owner <= 1'b0;
      end else if (data_win && !d_we) begin
        owner <= 1'b1;
      end
      if (!if_req || fetch_win) begin
        starve_cnt <= 4'd0;
      end else if (data_win && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Next state: any read grant moves to RDATA for one cycle; writes stay IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_win || (data_win && !d_we)) state_nxt = RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: memory drive from the winner, read data steered to the owner.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_ce    = 1'b0;
    mem_wre   = 1'b0;
    mem_ad    = '0;
    mem_din   = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (fetch_win) begin
      if_gnt = 1'b1;
      mem_ce = 1'b1;
      mem_ad = if_addr;
    end else if (data_win) begin
      d_gnt   = 1'b1;
      mem_ce  = 1'b1;
      mem_wre = d_we;
      mem_ad  = d_addr;
      mem_din = d_wdata;
    end
    if (rst && (state == RDATA)) begin
      if (owner) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_dout;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_dout;
      end
    end
  end

  // Debug view of the FSM.
  always_comb begin
    dbg_state = (state == RDATA);
  end

endmodule
